// File: rtl/plab2_proc_fetch_pkg.sv
// Shared types and helpers for the imem fetch buffer.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: default bus widths, the response-buffer entry layout {domain, data},
// and the width helpers for counters and ring pointers.
package plab2_proc_fetch_pkg;

  localparam int c_addr_nbits = 32;
  localparam int c_data_nbits = 32;

  // Response-buffer entry: the domain tag sits above the instruction word.
  typedef struct packed {
    logic                    domain;
    logic [c_data_nbits-1:0] data;
  } resp_entry_t;

  // A counter must hold the value n itself, hence the extra bit.
  function automatic int cnt_nbits(input int n);
    return $clog2(n) + 1;
  endfunction

  // Ring pointer width; a depth-1 ring still gets one bit.
  function automatic int ptr_nbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plab2_proc_imem_fetch_buffer_if.sv
// Generic val/rdy channel carrying one message word.
// Latency: n/a (wires only).
// Backpressure: the slave drops rdy; a transfer happens when val & rdy.
// Ports: val, msg (master -> slave), rdy (slave -> master).
interface plab2_proc_imem_fetch_buffer_if #(
  parameter int p_nbits = 32
) ();

  logic               val;
  logic               rdy;
  logic [p_nbits-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);

endinterface

// File: rtl/plab2_proc_imem_fetch_buffer_queue.sv
// In-order response buffer (normal queue, no bypass) with synchronous flush.
// Latency: 1 cycle enq -> deq.
// Backpressure: none on enq (caller guarantees space); deq holds until deq_rdy.
// Ports: clk, reset (sync active-low), flush, enq_val/enq_msg, deq_val/deq_rdy/deq_msg, count.
module plab2_proc_imem_fetch_buffer_queue
  import plab2_proc_fetch_pkg::*;
#(
  parameter  int p_nbits     = c_data_nbits + 1,
  parameter  int p_depth     = 4,
  localparam int p_cnt_nbits = cnt_nbits(p_depth),
  localparam int p_ptr_nbits = ptr_nbits(p_depth)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   enq_val,
  input  logic [p_nbits-1:0]     enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_nbits-1:0]     deq_msg,
  output logic [p_cnt_nbits-1:0] count
);

  logic [p_nbits-1:0]     mem_q [p_depth];
  logic [p_ptr_nbits-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [p_cnt_nbits-1:0] cnt_q, cnt_d;
  logic                   deq_fire;

  function automatic logic [p_ptr_nbits-1:0] ptr_inc(input logic [p_ptr_nbits-1:0] p);
    return (p == p_ptr_nbits'(p_depth - 1)) ? '0 : p + p_ptr_nbits'(1);
  endfunction

  assign deq_val = (cnt_q != '0);
  assign deq_msg = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_comb begin
    deq_fire = deq_val & deq_rdy;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (enq_val)  wr_ptr_d = ptr_inc(wr_ptr_q);
      if (deq_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + p_cnt_nbits'(enq_val) - p_cnt_nbits'(deq_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is qualified by the count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (enq_val && !flush) mem_q[wr_ptr_q] <= enq_msg;
  end

endmodule

// File: rtl/plab2_proc_imem_fetch_buffer.sv
// Instruction-fetch front end: credit-limited imem issue, in-order response buffer,
// squash via a drop counter, and per-fetch security-domain tagging.
// Latency: 1 cycle min imemresp -> fetchresp (no bypass); imemreq is a pass-through.
// Backpressure: fetchreq_rdy drops when live fetches reach p_max_inflight or imem stalls;
// imemresp is always accepted outside reset; fetchresp holds until fetchresp_rdy.
// Ports: clk, reset (sync active-low), sec_domain, squash, fetchreq (slave, msg=addr),
// imemreq (master, msg=addr), imemresp (slave, msg=data),
// fetchresp (master, msg={domain,data}), num_inflight.
module plab2_proc_imem_fetch_buffer
  import plab2_proc_fetch_pkg::*;
#(
  parameter  int p_addr_nbits   = c_addr_nbits,
  parameter  int p_data_nbits   = c_data_nbits,
  parameter  int p_max_inflight = 4,
  localparam int p_cnt_nbits    = cnt_nbits(p_max_inflight),
  localparam int p_ptr_nbits    = ptr_nbits(p_max_inflight)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sec_domain,
  input  logic                           squash,
  plab2_proc_imem_fetch_buffer_if.slave  fetchreq,   // p_addr_nbits wide
  plab2_proc_imem_fetch_buffer_if.master imemreq,    // p_addr_nbits wide
  plab2_proc_imem_fetch_buffer_if.slave  imemresp,   // p_data_nbits wide
  plab2_proc_imem_fetch_buffer_if.master fetchresp,  // p_data_nbits+1 wide
  output logic [p_cnt_nbits-1:0]         num_inflight
);

  // outs: kept requests awaiting memory; drop: squashed requests awaiting memory.
  logic [p_cnt_nbits-1:0] outs_q, outs_d, drop_q, drop_d;
  logic [p_cnt_nbits-1:0] buf_cnt, live;
  logic [p_ptr_nbits-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic                   tag_mem_q [p_max_inflight];
  logic                   can_issue, req_fire, resp_fire, resp_keep;
  logic                   buf_val;
  logic [p_data_nbits:0]  buf_msg;

  function automatic logic [p_ptr_nbits-1:0] ptr_inc(input logic [p_ptr_nbits-1:0] p);
    return (p == p_ptr_nbits'(p_max_inflight - 1)) ? '0 : p + p_ptr_nbits'(1);
  endfunction

  // Handshake outputs are gated by reset so they read 0 in every reset cycle.
  always_comb begin
    live          = outs_q + buf_cnt + drop_q;
    can_issue     = (live < p_cnt_nbits'(p_max_inflight));
    imemreq.val   = reset & fetchreq.val & can_issue;
    imemreq.msg   = fetchreq.msg;
    fetchreq.rdy  = reset & imemreq.rdy & can_issue;
    imemresp.rdy  = reset;
    req_fire      = fetchreq.val & fetchreq.rdy;
    resp_fire     = imemresp.val & imemresp.rdy;
    // A response arriving during a squash is older than the redirect, so it is dropped.
    resp_keep     = resp_fire & (drop_q == '0) & ~squash;
    fetchresp.val = reset & buf_val & ~squash;
    fetchresp.msg = buf_msg;
    num_inflight  = reset ? (outs_q + buf_cnt) : '0;
  end

  always_comb begin
    tag_wr_d = req_fire  ? ptr_inc(tag_wr_q) : tag_wr_q;
    // Every returning response pops its tag, dropped or not, keeping the ring aligned.
    tag_rd_d = resp_fire ? ptr_inc(tag_rd_q) : tag_rd_q;
    outs_d   = outs_q;
    drop_d   = drop_q;
    if (squash) begin
      // Everything still at memory becomes a drop; only the redirect target stays kept.
      drop_d = drop_q + outs_q - p_cnt_nbits'(resp_fire);
      outs_d = p_cnt_nbits'(req_fire);
    end else begin
      if (resp_fire && drop_q != '0) drop_d = drop_q - p_cnt_nbits'(1);
      outs_d = outs_q + p_cnt_nbits'(req_fire)
             - p_cnt_nbits'(resp_fire && drop_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      outs_q   <= '0;
      drop_q   <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      outs_q   <= outs_d;
      drop_q   <= drop_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tag_mem_q[tag_wr_q] <= sec_domain;
  end

  // Credit accounting guarantees the buffer has room whenever resp_keep is set.
  plab2_proc_imem_fetch_buffer_queue #(
    .p_nbits (p_data_nbits + 1),
    .p_depth (p_max_inflight)
  ) resp_buf (
    .clk     (clk),
    .reset   (reset),
    .flush   (squash),
    .enq_val (resp_keep),
    .enq_msg ({tag_mem_q[tag_rd_q], imemresp.msg}),
    .deq_val (buf_val),
    .deq_rdy (fetchresp.rdy & fetchresp.val),
    .deq_msg (buf_msg),
    .count   (buf_cnt)
  );

endmodule

// File: tb/tb_plab2_proc_imem_fetch_buffer.sv
// Self-checking bench: directed scenarios then a random phase, all cycles compared
// against a queue-based reference of in-flight fetches and buffered instructions.
// Memory is modelled in-order with configurable latency and stalls.
module tb_plab2_proc_imem_fetch_buffer;
  import plab2_proc_fetch_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  logic sec_domain;
  logic squash;
  logic [2:0] num_inflight;

  plab2_proc_imem_fetch_buffer_if #(.p_nbits(32)) fetchreq_if  ();
  plab2_proc_imem_fetch_buffer_if #(.p_nbits(32)) imemreq_if   ();
  plab2_proc_imem_fetch_buffer_if #(.p_nbits(32)) imemresp_if  ();
  plab2_proc_imem_fetch_buffer_if #(.p_nbits(33)) fetchresp_if ();

  plab2_proc_imem_fetch_buffer #(.p_max_inflight(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .sec_domain   (sec_domain),
    .squash       (squash),
    .fetchreq     (fetchreq_if),
    .imemreq      (imemreq_if),
    .imemresp     (imemresp_if),
    .fetchresp    (fetchresp_if),
    .num_inflight (num_inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tag;
    bit          keep;
    logic [31:0] addr;
    int          due;
  } inf_t;

  typedef struct {
    logic [31:0] data;
    logic        tag;
  } buf_t;

  inf_t inf_q[$];   // every fetch issued to memory, oldest first
  buf_t buf_q[$];   // instructions waiting for D

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int max_ninf = 0;
  int delivered = 0;
  bit first_seen = 0;
  logic [31:0] first_word = '0;

  bit f_val = 0, dom = 0, sq = 0, mrdy = 1, drdy = 1, mem_stall = 0;
  logic [31:0] f_addr = '0;
  int lat_min = 1, lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare at negedge+1, advance the reference.
  task automatic step();
    bit          r_val, can, exp_rdy, req_fire, exp_fv;
    int          kept;
    logic [31:0] w;
    resp_entry_t fr;
    inf_t        e;
    buf_t        b;
    @(negedge clk);
    reset = 1'b1;
    r_val = !mem_stall && inf_q.size() > 0 && inf_q[0].due <= cyc;
    w = r_val ? mem_word(inf_q[0].addr) : $urandom();
    imemresp_if.val  = r_val;
    imemresp_if.msg  = w;
    fetchreq_if.val  = f_val;
    fetchreq_if.msg  = f_addr;
    sec_domain       = dom;
    squash           = sq;
    imemreq_if.rdy   = mrdy;
    fetchresp_if.rdy = drdy;
    #1;
    can      = (inf_q.size() + buf_q.size()) < N;
    exp_rdy  = mrdy && can;
    req_fire = f_val && exp_rdy;
    exp_fv   = (buf_q.size() != 0) && !sq;
    kept = buf_q.size();
    foreach (inf_q[i]) if (inf_q[i].keep) kept++;
    chk("fetchreq_rdy", fetchreq_if.rdy, exp_rdy);
    chk("imemreq_val", imemreq_if.val, f_val && can);
    chk("imemreq_addr", imemreq_if.msg, f_addr);
    chk("imemresp_rdy", imemresp_if.rdy, 1);
    chk("fetchresp_val", fetchresp_if.val, exp_fv);
    chk("num_inflight", num_inflight, kept);
    if (exp_fv) begin
      fr = fetchresp_if.msg;
      chk("fetchresp_data", fr.data, buf_q[0].data);
      chk("fetchresp_domain", fr.domain, buf_q[0].tag);
    end
    if (fetchresp_if.val && drdy) begin
      fr = fetchresp_if.msg;
      delivered++;
      if (!first_seen) begin
        first_seen = 1;
        first_word = fr.data;
      end
    end
    if (int'(num_inflight) > max_ninf) max_ninf = int'(num_inflight);
    // reference update
    if (exp_fv && drdy) void'(buf_q.pop_front());
    if (r_val) begin
      e = inf_q.pop_front();
      if (e.keep && !sq) begin
        b.data = w;
        b.tag  = e.tag;
        buf_q.push_back(b);
      end
    end
    if (sq) begin
      foreach (inf_q[i]) inf_q[i].keep = 0;
      buf_q.delete();
    end
    if (req_fire) begin
      e.tag  = dom;
      e.keep = 1;
      e.addr = f_addr;
      e.due  = cyc + $urandom_range(lat_max, lat_min);
      inf_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      reset            = 1'b0;
      squash           = 1'b0;
      sec_domain       = 1'b1;
      fetchreq_if.val  = 1'b1;
      fetchreq_if.msg  = $urandom();
      imemreq_if.rdy   = 1'b1;
      imemresp_if.val  = 1'($urandom());
      imemresp_if.msg  = $urandom();
      fetchresp_if.rdy = 1'b1;
      #1;
      chk("rst_fetchreq_rdy", fetchreq_if.rdy, 0);
      chk("rst_imemreq_val", imemreq_if.val, 0);
      chk("rst_fetchresp_val", fetchresp_if.val, 0);
      chk("rst_imemresp_rdy", imemresp_if.rdy, 0);
      chk("rst_num_inflight", num_inflight, 0);
      @(posedge clk);
      cyc++;
    end
    // memory is reset alongside the block
    inf_q.delete();
    buf_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    squash = 1'b0;
    sec_domain = 1'b0;
    fetchreq_if.val = 1'b0;
    fetchreq_if.msg = '0;
    imemreq_if.rdy = 1'b0;
    imemresp_if.val = 1'b0;
    imemresp_if.msg = '0;
    fetchresp_if.rdy = 1'b0;

    do_reset(2);

    // steady stream, latency 1
    max_ninf = 0;
    first_seen = 0;
    for (int i = 0; i < 3; i++) begin
      f_val = 1;
      f_addr = 32'h1000 + 32'(4 * i);
      step();
    end
    f_val = 0;
    repeat (4) step();
    chk("stream_max_inflight", max_ninf <= 2, 1);
    chk("stream_first_word", first_word, mem_word(32'h1000));

    // credit stall: memory silent, fifth fetch refused
    mem_stall = 1;
    drdy = 0;
    f_val = 1;
    for (int i = 0; i < 5; i++) begin
      f_addr = 32'h3000 + 32'(4 * i);
      step();
    end
    #1;
    chk("stall_num_inflight", num_inflight, 4);
    chk("stall_fetchreq_rdy", fetchreq_if.rdy, 0);
    f_val = 0;
    mem_stall = 0;
    step();
    drdy = 1;
    step();
    #1;
    chk("stall_recover_rdy", fetchreq_if.rdy, 1);
    repeat (8) step();

    // squash with 3 outstanding + 1 buffered, redirect to 0x2000
    mem_stall = 1;
    drdy = 0;
    f_val = 1;
    for (int i = 0; i < 4; i++) begin
      f_addr = 32'h4000 + 32'(4 * i);
      step();
    end
    f_val = 0;
    mem_stall = 0;
    step();
    mem_stall = 1;
    sq = 1;
    f_val = 1;
    f_addr = 32'h2000;
    dom = 1;
    drdy = 1;
    step();
    #1;
    chk("squash_num_inflight", num_inflight, 0);
    sq = 0;
    first_seen = 0;
    step();
    f_val = 0;
    dom = 0;
    mem_stall = 0;
    repeat (10) step();
    chk("squash_first_word", first_word, mem_word(32'h2000));

    // squash while a response arrives, 2 outstanding
    mem_stall = 1;
    f_val = 1;
    for (int i = 0; i < 2; i++) begin
      f_addr = 32'h5000 + 32'(4 * i);
      step();
    end
    f_val = 0;
    mem_stall = 0;
    sq = 1;
    delivered = 0;
    step();
    #1;
    chk("squash_resp_num_inflight", num_inflight, 0);
    sq = 0;
    repeat (6) step();
    chk("squash_resp_discarded", delivered, 0);

    // domain tags 0,1,0 under variable latency and backpressure
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3; i++) begin
      f_val = 1;
      f_addr = 32'h6000 + 32'(4 * i);
      dom = (i == 1);
      do begin
        drdy = 1'($urandom_range(1, 0));
        step();
      end while (inf_q.size() == 0 || inf_q[inf_q.size()-1].addr != f_addr);
    end
    f_val = 0;
    drdy = 1;
    repeat (10) step();

    // reset mid-stream with 2 outstanding and 1 buffered
    lat_min = 3;
    lat_max = 3;
    drdy = 0;
    for (int i = 0; i < 4; i++) begin
      f_val = (i < 3);
      f_addr = 32'h7000 + 32'(4 * i);
      step();
    end
    do_reset(2);
    f_val = 0;
    step();
    #1;
    chk("post_reset_num_inflight", num_inflight, 0);
    chk("post_reset_fetchresp_val", fetchresp_if.val, 0);
    lat_min = 1;
    drdy = 1;
    f_val = 1;
    f_addr = 32'h8000;
    step();
    f_val = 0;
    repeat (6) step();

    // random traffic
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      f_val = ($urandom_range(9, 0) < 7);
      f_addr = {$urandom_range(16'hFFFF, 0), 16'h0} | 32'({$urandom_range(255, 0), 2'b00});
      dom = 1'($urandom());
      sq = ($urandom_range(19, 0) == 0);
      mrdy = ($urandom_range(9, 0) < 8);
      drdy = ($urandom_range(9, 0) < 7);
      if ($urandom_range(9, 0) == 0) mem_stall = !mem_stall;
      step();
    end
    sq = 0;
    f_val = 0;
    mem_stall = 0;
    drdy = 1;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/plab2_proc_imem_fetch_buffer.md
Name: plab2_proc_imem_fetch_buffer

Overview:
Parametrised instruction-fetch front end between the pipelined processor's fetch control and the instruction memory port. It supports up to p_max_inflight outstanding imem requests and buffers returned responses in order. On a redirect it squashes all in-flight and buffered fetches with a drop counter, not a single-message drop. Each fetch is tagged with the security domain active at issue, and that tag is returned with the instruction.

Parameters:
p_addr_nbits, 32, fetch address width
p_data_nbits, 32, instruction word width
p_max_inflight, 4, max requests issued but not yet consumed (outstanding + buffered); power of 2, >=1
p_cnt_nbits, $clog2(p_max_inflight)+1, counter width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on rising clk)
sec_domain  in  1  domain of the fetch issued this cycle
squash  in  1  redirect: discard all older fetches
fetchreq_val  in  1  ctrl has a fetch address
fetchreq_rdy  out  1  fetch accepted
fetchreq_addr  in  p_addr_nbits  fetch PC
imemreq_val  out  1  to memory
imemreq_rdy  in  1  memory accepts
imemreq_addr  out  p_addr_nbits  = fetchreq_addr (combinational pass-through)
imemresp_val  in  1  memory response valid
imemresp_rdy  out  1  constant 1 after reset (space is guaranteed)
imemresp_data  in  p_data_nbits  instruction
fetchresp_val  out  1  instruction available to D
fetchresp_rdy  in  1  D consumes
fetchresp_data  out  p_data_nbits  head instruction
fetchresp_domain  out  1  domain tag of head instruction
num_inflight  out  p_cnt_nbits  outstanding + buffered, for stats/debug

Behaviour:
- Reset (reset==0): all counters are 0, buffers are empty, and the drop count is 0. Outputs fetchreq_rdy=0, imemreq_val=0, fetchresp_val=0, imemresp_rdy=0 and num_inflight=0. This holds every reset cycle, including mid-operation; in-flight memory responses arriving after reset are not counted and the memory is also reset.
- Credit:
  - live = outstanding + buffered + drop_cnt.
  - can_issue = (live < p_max_inflight).
  - imemreq_val = fetchreq_val & can_issue.
  - fetchreq_rdy = imemreq_rdy & can_issue.
  - req_fire = fetchreq_val & fetchreq_rdy.
  - Dropped responses still hold credit until they return.
- Tag FIFO (depth p_max_inflight): push sec_domain on req_fire; pop on every imemresp fire (val & rdy), whether the response is kept or dropped.
- Response path:
  - imemresp fire with drop_cnt>0: the response and its tag are discarded and drop_cnt decrements.
  - Otherwise {data, tag} is enqueued in the response buffer (normal, non-bypass queue, depth p_max_inflight; 1-cycle min latency imemresp->fetchresp).
  - The buffer never overflows because of the credit rule.
- fetchresp_val = buffer nonempty & ~squash. Consume on fetchresp_val & fetchresp_rdy.
- Squash (evaluated at clock edge):
  - Buffer and tag entries of kept fetches are flushed.
  - drop_cnt_next = drop_cnt + outstanding − imemresp_fire, where outstanding counts requests issued before this cycle and not yet returned.
  - A req_fire in the squash cycle is the redirect target: it is not dropped and its tag is retained.
  - A response arriving in the squash cycle is discarded.
  - Back-to-back squashes accumulate correctly.
- Simultaneous req_fire, imemresp fire and fetchresp consume in one cycle: all take effect; counters net (+1 −1 −1).
- Full: live==p_max_inflight → fetchreq_rdy=0 and imemreq_val=0; this recovers the cycle after any consume or drop.
- Empty: fetchresp_val=0; no bypass from imemresp to fetchresp.
- Counter widths are p_cnt_nbits and never wrap (bounded by p_max_inflight). Pointers wrap mod p_max_inflight.

Decomposition:
- Shared package plab2_proc_fetch_pkg holds:
  - default widths (addr/data 32);
  - the resp-buffer entry layout {domain, data};
  - the counter-width function.
- Sub-module: the existing vc_Queue (VC_QUEUE_NORMAL, width p_data_nbits+1, depth p_max_inflight) as the response buffer, extended with a synchronous flush input. The tag FIFO and counters are local.

Test Plan:
- Steady stream, p_max_inflight=4, mem latency 1: fetch 0x1000,0x1004,0x1008 → fetchresp_data equals the mem words in order, one per cycle after a 2-cycle fill; num_inflight ≤2.
- Credit stall: mem never responds; 4 fetches accepted, 5th sees fetchreq_rdy=0 and num_inflight=4; one response + consume → rdy=1 next cycle.
- Squash with 3 outstanding and 1 buffered, redirect fetch to 0x2000 same cycle → buffered word never appears. The next 3 mem responses are dropped (drop_cnt 3→0). First fetchresp_data is the word for 0x2000.
- Squash while a response arrives in the same cycle with 2 outstanding → drop_cnt=1; that arriving word and one more are discarded.
- Domain tags: issue with sec_domain 0,1,0 → fetchresp_domain 0,1,0 paired with the correct words under variable mem latency and fetchresp_rdy backpressure.
- Reset held low for 2 cycles mid-stream (2 outstanding, 1 buffered) → all outputs 0. After release num_inflight=0, fetchresp_val=0 and new fetches proceed normally.
